// File: rtl/jelly_address_generator_2d.sv
// 2D address generator: expands one (base, step, stride, len_x, len_y) command into a stream of
// element addresses. Optional macro JELLY_ADDRESS_GENERATOR_2D_LINE_FLAG_EN adds m_line_first/m_line_last.
module jelly_address_generator_2d #(
  parameter  int ADDR_WIDTH  = 32,
  parameter  int LEN_X_WIDTH = 16,
  parameter  int LEN_Y_WIDTH = 16,
  parameter  int USER_WIDTH  = 0,
  localparam int USER_BITS   = (USER_WIDTH > 0) ? USER_WIDTH : 1
) (
  input  logic                   reset,
  input  logic                   clk,
  input  logic                   cke,

  input  logic [ADDR_WIDTH-1:0]  s_base,
  input  logic [ADDR_WIDTH-1:0]  s_step,
  input  logic [ADDR_WIDTH-1:0]  s_stride,
  input  logic [LEN_X_WIDTH-1:0] s_len_x,
  input  logic [LEN_Y_WIDTH-1:0] s_len_y,
  input  logic [USER_BITS-1:0]   s_user,
  input  logic                   s_valid,
  output logic                   s_ready,

  output logic [ADDR_WIDTH-1:0]  m_addr,
  output logic [USER_BITS-1:0]   m_user,
  output logic                   m_first,
  output logic                   m_last,
`ifdef JELLY_ADDRESS_GENERATOR_2D_LINE_FLAG_EN
  output logic                   m_line_first,
  output logic                   m_line_last,
`endif
  output logic                   m_valid,
  input  logic                   m_ready
);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  state_t                  state_r;
  state_t                  next_state_s;

  logic [ADDR_WIDTH-1:0]   step_r;
  logic [ADDR_WIDTH-1:0]   stride_r;
  logic [LEN_X_WIDTH-1:0]  len_x_r;
  logic [LEN_Y_WIDTH-1:0]  len_y_r;
  logic [USER_BITS-1:0]    user_r;
  logic [ADDR_WIDTH-1:0]   m_addr_r;
  logic [ADDR_WIDTH-1:0]   line_addr_r;
  logic [LEN_X_WIDTH-1:0]  x_r;
  logic [LEN_Y_WIDTH-1:0]  y_r;
  logic                    m_first_r;

  logic                    s_ready_s;
  logic                    m_valid_s;
  logic                    accept_s;
  logic                    beat_s;
  logic                    x_end_s;
  logic                    y_end_s;

  assign x_end_s = (x_r == len_x_r);
  assign y_end_s = (y_r == len_y_r);

  // Next-state and handshake decode
  always_comb begin
    next_state_s = state_r;
    s_ready_s    = 1'b0;
    m_valid_s    = 1'b0;
    accept_s     = 1'b0;
    beat_s       = 1'b0;
    case (state_r)
      ST_IDLE: begin
        s_ready_s = ~reset;
        accept_s  = s_valid & ~reset & cke;
        if (accept_s) begin
          next_state_s = ST_RUN;
        end else begin
          next_state_s = ST_IDLE;
        end
      end
      ST_RUN: begin
        m_valid_s = 1'b1;
        beat_s    = m_ready & cke;
        if (beat_s && x_end_s && y_end_s) begin
          next_state_s = ST_IDLE;
        end else begin
          next_state_s = ST_RUN;
        end
      end
      default: begin
        next_state_s = ST_IDLE;
      end
    endcase
  end

  // State register; cke=0 freezes the FSM
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= ST_IDLE;
    end else if (cke) begin
      state_r <= next_state_s;
    end else begin
      state_r <= state_r;
    end
  end

  // Command latch and address/counter datapath
  always_ff @(posedge clk) begin
    if (reset) begin
      step_r      <= {ADDR_WIDTH{1'b0}};
      stride_r    <= {ADDR_WIDTH{1'b0}};
      len_x_r     <= {LEN_X_WIDTH{1'b0}};
      len_y_r     <= {LEN_Y_WIDTH{1'b0}};
      user_r      <= {USER_BITS{1'b0}};
      m_addr_r    <= {ADDR_WIDTH{1'b0}};
      line_addr_r <= {ADDR_WIDTH{1'b0}};
      x_r         <= {LEN_X_WIDTH{1'b0}};
      y_r         <= {LEN_Y_WIDTH{1'b0}};
      m_first_r   <= 1'b0;
    end else if (cke) begin
      if (accept_s) begin
        step_r      <= s_step;
        stride_r    <= s_stride;
        len_x_r     <= s_len_x;
        len_y_r     <= s_len_y;
        user_r      <= s_user;
        m_addr_r    <= s_base;
        line_addr_r <= s_base;
        x_r         <= {LEN_X_WIDTH{1'b0}};
        y_r         <= {LEN_Y_WIDTH{1'b0}};
        m_first_r   <= 1'b1;
      end else if (beat_s) begin
        m_first_r <= 1'b0;
        if (!x_end_s) begin
          m_addr_r <= m_addr_r + step_r;
          x_r      <= x_r + LEN_X_WIDTH'(1);
        end else if (!y_end_s) begin
          // next line restarts from the line origin, not from the running element address
          line_addr_r <= line_addr_r + stride_r;
          m_addr_r    <= line_addr_r + stride_r;
          x_r         <= {LEN_X_WIDTH{1'b0}};
          y_r         <= y_r + LEN_Y_WIDTH'(1);
        end
      end
    end
  end

  assign s_ready = s_ready_s;
  assign m_valid = m_valid_s;
  assign m_addr  = m_addr_r;
  assign m_user  = user_r;
  assign m_first = m_first_r;
  assign m_last  = m_valid_s & x_end_s & y_end_s;

`ifdef JELLY_ADDRESS_GENERATOR_2D_LINE_FLAG_EN
  assign m_line_first = m_valid_s & (x_r == {LEN_X_WIDTH{1'b0}});
  assign m_line_last  = m_valid_s & x_end_s;
`endif

endmodule
